// File: rtl/seg_scan_ctrl.sv
// Two-digit multiplexed seven-segment scan controller for one hex byte.
// Optional leading-zero blanking of the upper digit is enabled with macro SEG_LZB_EN.

typedef enum logic {start, done} mode_t;

module seg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  mode_t      mode,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       busy
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   state_t        state, state_nx;
   logic [7:0]    data, data_nx;
   logic          idx, idx_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         data  <= '0;
         idx   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         data  <= data_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      data_nx  = data;
      idx_nx   = idx;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (din_valid && mode == start) begin
               data_nx  = din;
               idx_nx   = 1'b0;
               cnt_nx   = '0;
               state_nx = SCAN;
            end
         end
         SCAN, HOLD: begin
            if (cnt == CNT_MAX) begin
               cnt_nx = '0;
               idx_nx = ~idx;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
            // SCAN accepts every valid byte; HOLD only takes one alongside its exit
            if (state == SCAN) begin
               if (din_valid) data_nx = din;
               if (mode == done) state_nx = HOLD;
            end else if (mode == start) begin
               if (din_valid) data_nx = din;
               state_nx = SCAN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign nib     = idx ? data[7:4] : data[3:0];
   assign seg_dec = hex7(nib);

   always_comb begin
      seg       = '0;
      an        = '0;
      din_ready = 1'b1;
      busy      = 1'b0;
      if (state != IDLE) begin
         busy      = 1'b1;
         din_ready = (state == SCAN);
         an        = idx ? 2'b10 : 2'b01;
`ifdef SEG_LZB_EN
         seg       = (idx && data[7:4] == 4'h0) ? 7'h00 : seg_dec;
`else
         seg       = seg_dec;
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench: two scan controllers (REFRESH_DIV 4 and 2) driven in parallel
// against a phase-counter reference model; directed scenarios then random traffic.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   mode_t      mode;
   logic [7:0] din;
   logic       din_valid;

   logic       rdy_o  [2];
   logic [6:0] seg_o  [2];
   logic [1:0] an_o   [2];
   logic       busy_o [2];

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // reference: mode 0=idle 1=scan 2=hold; ph = cycles into the 2*div scan period
   int         m_st [2];
   int         m_ph [2];
   int         m_dv [2];
   logic [7:0] m_by [2];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.REFRESH_DIV(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .din_valid(din_valid),
      .din_ready(rdy_o[0]), .seg(seg_o[0]), .an(an_o[0]), .busy(busy_o[0]));

   seg_scan_ctrl #(.REFRESH_DIV(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .din_valid(din_valid),
      .din_ready(rdy_o[1]), .seg(seg_o[1]), .an(an_o[1]), .busy(busy_o[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_st[k] = 0; m_by[k] = 8'h00; m_ph[k] = 0;
         end else begin
            case (m_st[k])
               0: if (din_valid && mode == start) begin
                     m_by[k] = din; m_ph[k] = 0; m_st[k] = 1;
                  end
               1: begin
                     if (din_valid) m_by[k] = din;
                     m_ph[k] = (m_ph[k] + 1) % (2 * m_dv[k]);
                     if (mode == done) m_st[k] = 2;
                  end
               default: begin
                     m_ph[k] = (m_ph[k] + 1) % (2 * m_dv[k]);
                     if (mode == start) begin
                        if (din_valid) m_by[k] = din;
                        m_st[k] = 1;
                     end
                  end
            endcase
         end
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         logic [6:0] es; logic [1:0] ea; logic er, eb;
         int idx;
         es = 7'h00; ea = 2'b00; er = 1'b1; eb = 1'b0;
         if (m_st[k] != 0) begin
            idx = m_ph[k] / m_dv[k];
            es  = SEG_TBL[idx == 1 ? m_by[k][7:4] : m_by[k][3:0]];
`ifdef SEG_LZB_EN
            if (idx == 1 && m_by[k][7:4] == 4'h0) es = 7'h00;
`endif
            ea = (idx == 1) ? 2'b10 : 2'b01;
            er = (m_st[k] == 1);
            eb = 1'b1;
         end
         check($sformatf("seg%0d", k),  32'(seg_o[k]),  32'(es));
         check($sformatf("an%0d", k),   32'(an_o[k]),   32'(ea));
         check($sformatf("rdy%0d", k),  32'(rdy_o[k]),  32'(er));
         check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(eb));
      end
   endtask

   task automatic drive(input logic r, input mode_t m, input logic v, input logic [7:0] d);
      rst_n = r; mode = m; din_valid = v; din = d;
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_outputs();
      end
   endtask

   initial begin
      m_dv[0] = 4; m_dv[1] = 2;
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_ph[k] = 0; m_by[k] = 8'h00;
      end
      @(negedge clk);

      // reset with a stray valid byte
      drive(1'b0, start, 1'b1, 8'h99); step(2);
      check("rst_seg", 32'(seg_o[0]), 32'h00);
      check("rst_busy", 32'(busy_o[0]), 32'h0);

      // capture 0xA5 and scan a few periods
      drive(1'b1, start, 1'b1, 8'hA5); step();
      check("a5_lo", 32'(seg_o[0]), 32'h6D);
      drive(1'b1, start, 1'b0, 8'h00); step(4);
      check("a5_hi", 32'(seg_o[0]), 32'h77);
      step(9);

      // mid-slot replacement
      drive(1'b1, start, 1'b1, 8'h18); step();
      drive(1'b1, start, 1'b0, 8'h00); step(7);

      // capture with done, then frozen hold
      drive(1'b1, done, 1'b1, 8'h3C); step();
      check("hold_rdy", 32'(rdy_o[0]), 32'h0);
      drive(1'b1, done, 1'b1, 8'hFF); step(10);
      drive(1'b1, start, 1'b0, 8'h00); step(3);

      // back to idle, then leading-zero digit
      drive(1'b0, start, 1'b0, 8'h00); step();
      drive(1'b1, done, 1'b1, 8'h55); step(2);
      drive(1'b1, start, 1'b1, 8'h07); step();
      drive(1'b1, start, 1'b0, 8'h00); step(4);
`ifdef SEG_LZB_EN
      check("lzb_seg", 32'(seg_o[0]), 32'h00);
`else
      check("lzb_seg", 32'(seg_o[0]), 32'h3F);
`endif
      check("lzb_an", 32'(an_o[0]), 32'h2);

      // reset mid-slot while index is 1
      step();
      drive(1'b0, start, 1'b1, 8'h12); step();
      check("midrst_an", 32'(an_o[0]), 32'h0);
      check("midrst_busy", 32'(busy_o[0]), 32'h0);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(39) != 0),
               ($urandom_range(4) == 0) ? done : start,
               $urandom_range(2) == 0,
               8'($urandom));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
